// File: rtl/pll_lock_sequencer.sv
// PLL start-up and lock supervisor: pulses PLL enable, settles, measures the
// divided feedback against osc, and switches the clock mux only after a passing window.
module pll_lock_sequencer #(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 4096,
    parameter int WIN_MULT   = 16,
    parameter int TOL        = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic        osc,
    input  logic        resetb,
    input  logic        start,
    input  logic [4:0]  cfg_div,
    input  logic        fb_sync,
    output logic        pll_enable,
    output logic [4:0]  pll_div,
    output logic        clk_sel,
    output logic        locked,
    output logic        fail,
    output logic        lost_lock,
    output logic [3:0]  attempts,
    output logic [11:0] meas_count,
    output logic [2:0]  state
);

    // state   | meaning
    // IDLE    | waiting for start, PLL disabled
    // RESET   | pll_enable held low for RST_CYC cycles
    // SETTLE  | pll_enable high, waiting SETTLE_CYC cycles
    // MEASURE | counting fb_sync rising edges over 64*WIN_MULT cycles
    // CHECK   | compare count against pll_div*WIN_MULT
    // LOCKED  | PLL in use, launches next monitoring window
    // FAIL    | retries exhausted or invalid divider, waits for start=0
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_CHECK   = 3'd4,
        ST_LOCKED  = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    localparam logic [15:0] RST_LOAD    = 16'(RST_CYC - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] WIN_LOAD    = 16'(64 * WIN_MULT - 1);
    localparam logic [3:0]  RETRY_LIM   = 4'(MAX_RETRY);

    state_t       state_q, state_d;
    logic [15:0]  timer_q, timer_d;
    logic [11:0]  edge_cnt_q, edge_cnt_d;
    logic         fb_q;
    logic         mon_q, mon_d;
    logic         pll_enable_q, pll_enable_d;
    logic [4:0]   pll_div_q, pll_div_d;
    logic         clk_sel_q, clk_sel_d;
    logic         locked_q, locked_d;
    logic         fail_q, fail_d;
    logic         lost_lock_q, lost_lock_d;
    logic [3:0]   attempts_q, attempts_d;
    logic [11:0]  meas_count_q, meas_count_d;

    logic               fb_rise;
    logic [12:0]        exp_cnt;
    logic signed [12:0] diff;
    logic signed [12:0] abs_diff;
    logic               pass;

    assign fb_rise  = fb_sync & ~fb_q;
    assign exp_cnt  = 13'(pll_div_q) * 13'(WIN_MULT);
    assign diff     = $signed({1'b0, edge_cnt_q}) - $signed(exp_cnt);
    assign abs_diff = (diff < 0) ? -diff : diff;
    assign pass     = (abs_diff <= $signed(13'(TOL)));

    always_ff @(posedge osc or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            edge_cnt_q   <= '0;
            fb_q         <= 1'b0;
            mon_q        <= 1'b0;
            pll_enable_q <= 1'b0;
            pll_div_q    <= 5'd5;
            clk_sel_q    <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            lost_lock_q  <= 1'b0;
            attempts_q   <= '0;
            meas_count_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            edge_cnt_q   <= edge_cnt_d;
            fb_q         <= fb_sync;
            mon_q        <= mon_d;
            pll_enable_q <= pll_enable_d;
            pll_div_q    <= pll_div_d;
            clk_sel_q    <= clk_sel_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            lost_lock_q  <= lost_lock_d;
            attempts_q   <= attempts_d;
            meas_count_q <= meas_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        edge_cnt_d   = edge_cnt_q;
        mon_d        = mon_q;
        pll_enable_d = pll_enable_q;
        pll_div_d    = pll_div_q;
        clk_sel_d    = clk_sel_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        lost_lock_d  = lost_lock_q;
        attempts_d   = attempts_q;
        meas_count_d = meas_count_q;

        unique case (state_q)
            ST_IDLE: begin
                pll_enable_d = 1'b0;
                clk_sel_d    = 1'b0;
                locked_d     = 1'b0;
                fail_d       = 1'b0;
                mon_d        = 1'b0;
                if (start) begin
                    if (cfg_div != 5'd0) begin
                        state_d     = ST_RESET;
                        pll_div_d   = cfg_div;
                        attempts_d  = '0;
                        lost_lock_d = 1'b0;
                        timer_d     = RST_LOAD;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end
                end
            end
            ST_RESET: begin
                if (timer_q == '0) begin
                    state_d      = ST_SETTLE;
                    pll_enable_d = 1'b1;
                    timer_d      = SETTLE_LOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d    = ST_MEASURE;
                    timer_d    = WIN_LOAD;
                    edge_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_MEASURE: begin
                if (fb_rise && (edge_cnt_q != 12'hFFF)) begin
                    edge_cnt_d = edge_cnt_q + 12'd1;
                end
                if (timer_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_CHECK: begin
                meas_count_d = edge_cnt_q;
                if (pass) begin
                    state_d   = ST_LOCKED;
                    clk_sel_d = 1'b1;
                    locked_d  = 1'b1;
                    mon_d     = 1'b1;
                end else if (mon_q) begin
                    // lock lost while in use: drop back to bypass and restart bring-up
                    state_d      = ST_RESET;
                    lost_lock_d  = 1'b1;
                    attempts_d   = '0;
                    clk_sel_d    = 1'b0;
                    locked_d     = 1'b0;
                    mon_d        = 1'b0;
                    pll_enable_d = 1'b0;
                    timer_d      = RST_LOAD;
                end else if ((attempts_q + 4'd1) == RETRY_LIM) begin
                    state_d      = ST_FAIL;
                    attempts_d   = attempts_q + 4'd1;
                    fail_d       = 1'b1;
                    pll_enable_d = 1'b0;
                    clk_sel_d    = 1'b0;
                end else begin
                    state_d      = ST_RESET;
                    attempts_d   = attempts_q + 4'd1;
                    pll_enable_d = 1'b0;
                    timer_d      = RST_LOAD;
                end
            end
            ST_LOCKED: begin
                state_d    = ST_MEASURE;
                timer_d    = WIN_LOAD;
                edge_cnt_d = '0;
            end
            ST_FAIL: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    fail_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && !start) begin
            state_d      = ST_IDLE;
            pll_enable_d = 1'b0;
            clk_sel_d    = 1'b0;
            locked_d     = 1'b0;
            fail_d       = 1'b0;
            mon_d        = 1'b0;
        end
    end

    assign pll_enable = pll_enable_q;
    assign pll_div    = pll_div_q;
    assign clk_sel    = clk_sel_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign lost_lock  = lost_lock_q;
    assign attempts   = attempts_q;
    assign meas_count = meas_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: bring-up timing, tolerance edges,
// retry exhaustion, lock loss, abort, async reset and invalid divider.
module tb_pll_lock_sequencer;

    logic        osc;
    logic        resetb;
    logic        start;
    logic [4:0]  cfg_div;
    logic        fb_sync;
    logic        pll_enable;
    logic [4:0]  pll_div;
    logic        clk_sel;
    logic        locked;
    logic        fail;
    logic        lost_lock;
    logic [3:0]  attempts;
    logic [11:0] meas_count;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    // phase accumulator: an increment of N<<22 gives exactly N rising edges per 1024 cycles
    logic [31:0] fb_acc = '0;
    logic [31:0] fb_inc = '0;

    pll_lock_sequencer #(
        .RST_CYC   (16),
        .SETTLE_CYC(64),
        .WIN_MULT  (16),
        .TOL       (2),
        .MAX_RETRY (3)
    ) dut (
        .osc       (osc),
        .resetb    (resetb),
        .start     (start),
        .cfg_div   (cfg_div),
        .fb_sync   (fb_sync),
        .pll_enable(pll_enable),
        .pll_div   (pll_div),
        .clk_sel   (clk_sel),
        .locked    (locked),
        .fail      (fail),
        .lost_lock (lost_lock),
        .attempts  (attempts),
        .meas_count(meas_count),
        .state     (state)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    always @(negedge osc) begin
        fb_acc  = fb_acc + fb_inc;
        fb_sync = fb_acc[31];
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge osc);
        @(negedge osc);
    endtask

    task automatic set_fb(input int n_edges);
        fb_inc  = 32'(n_edges) << 22;
        fb_acc  = '0;
        fb_sync = 1'b0;
    endtask

    task automatic test_reset;
        resetb  = 1'b0;
        start   = 1'b0;
        cfg_div = 5'd0;
        fb_sync = 1'b0;
        repeat (3) @(negedge osc);
        checks++;
        if ({state, pll_enable, clk_sel, locked, fail, lost_lock} !== 8'b000_00000) begin
            $display("FAIL reset_ctrl: got state=%0d en=%b sel=%b lk=%b fail=%b lost=%b, want all 0",
                     state, pll_enable, clk_sel, locked, fail, lost_lock);
            errors++;
        end
        checks++;
        if (pll_div !== 5'd5 || attempts !== 4'd0 || meas_count !== 12'd0) begin
            $display("FAIL reset_regs: got div=%0d att=%0d meas=%0d, want 5/0/0", pll_div, attempts, meas_count);
            errors++;
        end
        resetb = 1'b1;
        cycles(2);
    endtask

    task automatic test_lock;
        set_fb(80);
        cfg_div = 5'd5;
        start   = 1'b1;
        cycles(1);
        checks++;
        if (state !== 3'd1 || pll_enable !== 1'b0 || pll_div !== 5'd5) begin
            $display("FAIL lock_enter_reset: got state=%0d en=%b div=%0d, want 1/0/5", state, pll_enable, pll_div);
            errors++;
        end
        cycles(16);
        checks++;
        if (state !== 3'd2 || pll_enable !== 1'b1) begin
            $display("FAIL lock_settle: got state=%0d en=%b, want 2/1", state, pll_enable);
            errors++;
        end
        cycles(64 + 1024);
        checks++;
        if (state !== 3'd4 || locked !== 1'b0) begin
            $display("FAIL lock_check: got state=%0d locked=%b, want 4/0", state, locked);
            errors++;
        end
        cycles(1);
        checks++;
        if (state !== 3'd5 || locked !== 1'b1 || clk_sel !== 1'b1 || meas_count !== 12'd80 || attempts !== 4'd0) begin
            $display("FAIL lock_done: got state=%0d lk=%b sel=%b meas=%0d att=%0d, want 5/1/1/80/0",
                     state, locked, clk_sel, meas_count, attempts);
            errors++;
        end
        cycles(1);
        checks++;
        if (state !== 3'd3 || locked !== 1'b1 || clk_sel !== 1'b1) begin
            $display("FAIL lock_monitor: got state=%0d lk=%b sel=%b, want 3/1/1", state, locked, clk_sel);
            errors++;
        end
    endtask

    task automatic test_lock_loss;
        set_fb(0);
        cycles(1023);
        checks++;
        if (state !== 3'd3 || locked !== 1'b1 || clk_sel !== 1'b1) begin
            $display("FAIL loss_window: got state=%0d lk=%b sel=%b, want 3/1/1", state, locked, clk_sel);
            errors++;
        end
        cycles(2);
        checks++;
        if (state !== 3'd1 || locked !== 1'b0 || clk_sel !== 1'b0 || lost_lock !== 1'b1 ||
            attempts !== 4'd0 || pll_enable !== 1'b0 || meas_count !== 12'd0) begin
            $display("FAIL loss_detect: got state=%0d lk=%b sel=%b lost=%b att=%0d en=%b meas=%0d, want 1/0/0/1/0/0/0",
                     state, locked, clk_sel, lost_lock, attempts, pll_enable, meas_count);
            errors++;
        end
        set_fb(80);
        cycles(1105);
        checks++;
        if (state !== 3'd5 || locked !== 1'b1 || clk_sel !== 1'b1 || lost_lock !== 1'b1 || meas_count !== 12'd80) begin
            $display("FAIL loss_relock: got state=%0d lk=%b sel=%b lost=%b meas=%0d, want 5/1/1/1/80",
                     state, locked, clk_sel, lost_lock, meas_count);
            errors++;
        end
    endtask

    task automatic test_abort;
        cycles(101);
        checks++;
        if (state !== 3'd3) begin
            $display("FAIL abort_pre: got state=%0d, want 3", state);
            errors++;
        end
        start = 1'b0;
        cycles(1);
        checks++;
        if ({state, pll_enable, clk_sel, locked, fail} !== 7'b000_0000) begin
            $display("FAIL abort: got state=%0d en=%b sel=%b lk=%b fail=%b, want all 0",
                     state, pll_enable, clk_sel, locked, fail);
            errors++;
        end
        cycles(1);
    endtask

    task automatic test_tolerance;
        int n_tab[3]  = '{78, 82, 77};
        bit lk_tab[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_fb(n_tab[i]);
            cfg_div = 5'd5;
            start   = 1'b1;
            cycles(1106);
            checks++;
            if (lk_tab[i]) begin
                if (state !== 3'd5 || locked !== 1'b1 || meas_count !== 12'(n_tab[i]) || attempts !== 4'd0) begin
                    $display("FAIL tol_%0d: got state=%0d lk=%b meas=%0d att=%0d, want 5/1/%0d/0",
                             n_tab[i], state, locked, meas_count, attempts, n_tab[i]);
                    errors++;
                end
            end else begin
                if (state !== 3'd1 || locked !== 1'b0 || attempts !== 4'd1 || pll_enable !== 1'b0 ||
                    meas_count !== 12'(n_tab[i])) begin
                    $display("FAIL tol_%0d: got state=%0d lk=%b att=%0d en=%b meas=%0d, want 1/0/1/0/%0d",
                             n_tab[i], state, locked, attempts, pll_enable, meas_count, n_tab[i]);
                    errors++;
                end
                cycles(15);
                checks++;
                if (state !== 3'd1 || pll_enable !== 1'b0) begin
                    $display("FAIL tol_reset_hold: got state=%0d en=%b, want 1/0", state, pll_enable);
                    errors++;
                end
                cycles(1);
                checks++;
                if (state !== 3'd2 || pll_enable !== 1'b1) begin
                    $display("FAIL tol_reset_end: got state=%0d en=%b, want 2/1", state, pll_enable);
                    errors++;
                end
            end
            start = 1'b0;
            cycles(2);
        end
    endtask

    task automatic test_no_feedback;
        set_fb(0);
        cfg_div = 5'd5;
        start   = 1'b1;
        cycles(1106);
        checks++;
        if (state !== 3'd1 || attempts !== 4'd1) begin
            $display("FAIL nofb_try1: got state=%0d att=%0d, want 1/1", state, attempts);
            errors++;
        end
        cycles(1105);
        checks++;
        if (state !== 3'd1 || attempts !== 4'd2) begin
            $display("FAIL nofb_try2: got state=%0d att=%0d, want 1/2", state, attempts);
            errors++;
        end
        cycles(1105);
        checks++;
        if (state !== 3'd6 || fail !== 1'b1 || attempts !== 4'd3 || pll_enable !== 1'b0 || clk_sel !== 1'b0) begin
            $display("FAIL nofb_fail: got state=%0d fail=%b att=%0d en=%b sel=%b, want 6/1/3/0/0",
                     state, fail, attempts, pll_enable, clk_sel);
            errors++;
        end
        cycles(5);
        checks++;
        if (state !== 3'd6 || fail !== 1'b1) begin
            $display("FAIL nofb_hold: got state=%0d fail=%b, want 6/1", state, fail);
            errors++;
        end
        start = 1'b0;
        cycles(1);
        checks++;
        if (state !== 3'd0 || fail !== 1'b0) begin
            $display("FAIL nofb_release: got state=%0d fail=%b, want 0/0", state, fail);
            errors++;
        end
    endtask

    task automatic test_reset_mid_settle;
        set_fb(80);
        cfg_div = 5'd9;
        start   = 1'b1;
        cycles(30);
        checks++;
        if (state !== 3'd2 || pll_div !== 5'd9 || pll_enable !== 1'b1) begin
            $display("FAIL rst_pre: got state=%0d div=%0d en=%b, want 2/9/1", state, pll_div, pll_enable);
            errors++;
        end
        #1 resetb = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || pll_div !== 5'd5 || pll_enable !== 1'b0 || clk_sel !== 1'b0 || locked !== 1'b0) begin
            $display("FAIL rst_async: got state=%0d div=%0d en=%b sel=%b lk=%b, want 0/5/0/0/0",
                     state, pll_div, pll_enable, clk_sel, locked);
            errors++;
        end
        start = 1'b0;
        @(negedge osc);
        resetb = 1'b1;
        cycles(1);
    endtask

    task automatic test_invalid_div;
        cfg_div = 5'd0;
        start   = 1'b1;
        cycles(1);
        checks++;
        if (state !== 3'd6 || fail !== 1'b1 || pll_enable !== 1'b0) begin
            $display("FAIL inval_div: got state=%0d fail=%b en=%b, want 6/1/0", state, fail, pll_enable);
            errors++;
        end
        cycles(3);
        checks++;
        if (pll_enable !== 1'b0 || state !== 3'd6) begin
            $display("FAIL inval_hold: got state=%0d en=%b, want 6/0", state, pll_enable);
            errors++;
        end
        start = 1'b0;
        cycles(1);
        checks++;
        if (state !== 3'd0 || fail !== 1'b0) begin
            $display("FAIL inval_release: got state=%0d fail=%b, want 0/0", state, fail);
            errors++;
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_lock_loss;
        test_abort;
        test_tolerance;
        test_no_feedback;
        test_reset_mid_settle;
        test_invalid_div;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Autonomous start-up and lock supervisor for the SPI-configured digital PLL, clocked from the reference oscillator `osc`. On request it:
- pulses the PLL enable (reset),
- waits a settle time,
- measures PLL output frequency against `osc`,
- switches the system clock mux to the PLL only after a measurement passes.

It retries on failure, monitors lock continuously, and falls back to the bypass clock on lock loss.

Parameters:
- RST_CYC, 16: `osc` cycles `pll_enable` is held low per attempt.
- SETTLE_CYC, 4096: `osc` cycles between enable and first measurement.
- WIN_MULT, 16: measurement window = 64*WIN_MULT `osc` cycles; expected count = div*WIN_MULT.
- TOL, 2: allowed absolute count error.
- MAX_RETRY, 3: total failed checks permitted before FAIL (1..15).

Ports:
- osc  input  1  reference clock; all logic on posedge.
- resetb  input  1  reset, asynchronous, active-low.
- start  input  1  level request; 1 = bring up PLL, 0 = abort/stop.
- cfg_div  input  5  requested multiplier; captured on leaving IDLE.
- fb_sync  input  1  PLL clock divided by 64, already 2-FF synchronized to `osc`.
- pll_enable  output  1  drives PLL enable.
- pll_div  output  5  captured divider to PLL.
- clk_sel  output  1  0 = bypass (`osc`), 1 = PLL clock (external glitch-free mux).
- locked  output  1  measurement passed; PLL in use.
- fail  output  1  retries exhausted or invalid divider.
- lost_lock  output  1  sticky; lock was lost since last start.
- attempts  output  4  failed checks in the current bring-up.
- meas_count  output  12  last completed window count.
- state  output  3  current FSM state code.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except `pll_div`=5; internal counters 0; `fb_q`=0.
- Encodings: IDLE=0, RESET=1, SETTLE=2, MEASURE=3, CHECK=4, LOCKED=5, FAIL=6.
- Registered outputs: every output is a register updated on the transition edge into a state.

State transitions:
- **IDLE**: outputs 0.
  - `start`=1 and `cfg_div`≠0 → RESET; capture `pll_div`; clear `attempts` and `lost_lock`.
  - `start`=1 and `cfg_div`=0 → FAIL.
- **RESET**: `pll_enable`=0 for exactly RST_CYC cycles → SETTLE.
- **SETTLE**: `pll_enable`=1 for exactly SETTLE_CYC cycles → MEASURE.
- **MEASURE**:
  - Edge counter cleared on entry.
  - Counts rising edges of `fb_sync` (`fb_sync` & ~`fb_q`, `fb_q` always sampling) over exactly 64*WIN_MULT cycles.
  - Counter saturates at 4095.
  - → CHECK.
- **CHECK** (one cycle):
  - `meas_count` ← count.
  - pass = |count − `pll_div`*WIN_MULT| ≤ TOL, using 13-bit signed arithmetic.
  - Pass → LOCKED with `clk_sel`=1, `locked`=1.
  - Fail with `attempts`+1 = MAX_RETRY → FAIL.
  - Fail otherwise → RESET; `attempts` incremented in both fail cases.
  - If checking after LOCKED, a fail sets `lost_lock`=1, clears `attempts`, clears `clk_sel`/`locked` and → RESET.
- **LOCKED**: immediately starts the next window (MEASURE with a locked flag held); windows run back to back. `clk_sel`/`locked` remain 1 through MEASURE/CHECK while monitoring.
- **FAIL**: `fail`=1, `pll_enable`=0, `clk_sel`=0; held until `start`=0 → IDLE, which clears `fail`.

Abort and reset:
- `start`=0 in any state other than IDLE → IDLE next cycle.
- On abort, `pll_enable`, `clk_sel` and `locked` go 0 on that edge.
- `resetb` low mid-operation overrides everything asynchronously.

Test Plan:
- **Lock:** SETTLE_CYC=64, `cfg_div`=5, `fb_sync` toggling every 6.4 `osc` cycles on average (80 edges/1024 cycles), `start`=1.
  - Required: `locked`=`clk_sel`=1 after 1+16+64+1024+1 cycles; `meas_count`=80; `attempts`=0.
- **Tolerance boundary:** `cfg_div`=5 with 78 edges → locks; 82 → locks; 77 → `attempts`=1 and RESET re-entered (`pll_enable` low 16 cycles).
- **No feedback:** `fb_sync`=0.
  - Required: 3 checks fail; `fail`=1, `attempts`=3, `pll_enable`=0, `clk_sel`=0.
  - Then `start`=0 → IDLE next cycle, `fail`=0.
- **Lock loss:** after lock, stop `fb_sync`.
  - Required: at the next CHECK, `locked`=`clk_sel`=0 and `lost_lock`=1; RESET entered.
  - Restore `fb_sync` → relocks with `lost_lock` still 1.
- **Abort/reset:**
  - `start`=0 mid-MEASURE → state=0 next cycle, all control outputs 0.
  - `resetb` low mid-SETTLE → outputs reset asynchronously; `pll_div`=5.
- **Invalid divider:** `cfg_div`=0 with `start`=1 → FAIL in one cycle, `pll_enable` never asserted.
